// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: FSM state encoding and width default.
package dmem_pkg;

    localparam int unsigned DbitsDefault = 32;

    typedef logic [1:0] state_t;

    localparam state_t StIdle = 2'd0;
    localparam state_t StGnt0 = 2'd1;
    localparam state_t StGnt1 = 2'd2;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: chooses a requester, preferring the one not granted last.
module rr_pick2 (
    input  logic req0_i,
    input  logic req1_i,
    input  logic last_i,
    output logic valid_o,
    output logic idx_o
);

    // On a tie the requester that did not win last time is chosen.
    always_comb begin
        valid_o = req0_i | req1_i;
        if (req0_i && req1_i) begin
            idx_o = ~last_i;
        end else begin
            idx_o = req1_i;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates two requesters (CPU, DMA/debug) onto a single data memory / I-O port.
// Each access takes one grant cycle; completion is a one-cycle ACK with registered read data.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int unsigned DBITS   = DbitsDefault,
    parameter int unsigned RRSTART = 1
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             R0_REQ,
    input  logic             R0_WE,
    input  logic [DBITS-1:0] R0_ADDR,
    input  logic [DBITS-1:0] R0_DIN,
    output logic             R0_ACK,
    output logic [DBITS-1:0] R0_DOUT,
    input  logic             R1_REQ,
    input  logic             R1_WE,
    input  logic [DBITS-1:0] R1_ADDR,
    input  logic [DBITS-1:0] R1_DIN,
    output logic             R1_ACK,
    output logic [DBITS-1:0] R1_DOUT,
    output logic [DBITS-1:0] M_ADDR,
    output logic [DBITS-1:0] M_DIN,
    output logic             M_WE,
    input  logic [DBITS-1:0] M_DOUT
);

    state_t           state_q, state_d;
    logic             last_q, last_d;
    logic             ack0_q, ack0_d;
    logic             ack1_q, ack1_d;
    logic [DBITS-1:0] dout0_q, dout0_d;
    logic [DBITS-1:0] dout1_q, dout1_d;

    logic pick_valid;
    logic pick_idx;

    rr_pick2 u_pick (
        .req0_i  (R0_REQ),
        .req1_i  (R1_REQ),
        .last_i  (last_q),
        .valid_o (pick_valid),
        .idx_o   (pick_idx)
    );

    // Next-state: arbitrate in idle, complete the access on the edge leaving a grant state.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
        dout0_d = dout0_q;
        dout1_d = dout1_q;
        case (state_q)
            StIdle: begin
                if (pick_valid) begin
                    state_d = pick_idx ? StGnt1 : StGnt0;
                end
            end
            StGnt0: begin
                state_d = StIdle;
                ack0_d  = 1'b1;
                last_d  = 1'b0;
                if (!R0_WE) begin
                    dout0_d = M_DOUT;
                end
            end
            StGnt1: begin
                state_d = StIdle;
                ack1_d  = 1'b1;
                last_d  = 1'b1;
                if (!R1_WE) begin
                    dout1_d = M_DOUT;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers with synchronous reset; reset in a grant state drops the access silently.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= StIdle;
            last_q  <= (RRSTART != 0);
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            dout0_q <= '0;
            dout1_q <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
            dout0_q <= dout0_d;
            dout1_q <= dout1_d;
        end
    end

    // Memory port mux; write enable is gated by RESET so an aborted grant never writes.
    always_comb begin
        M_ADDR = '0;
        M_DIN  = '0;
        M_WE   = 1'b0;
        case (state_q)
            StGnt0: begin
                M_ADDR = R0_ADDR;
                M_DIN  = R0_DIN;
                M_WE   = R0_WE & ~RESET;
            end
            StGnt1: begin
                M_ADDR = R1_ADDR;
                M_DIN  = R1_DIN;
                M_WE   = R1_WE & ~RESET;
            end
            default: begin
                M_ADDR = '0;
                M_DIN  = '0;
                M_WE   = 1'b0;
            end
        endcase
    end

    assign R0_ACK  = ack0_q;
    assign R1_ACK  = ack1_q;
    assign R0_DOUT = dout0_q;
    assign R1_DOUT = dout1_q;

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter DBITS, default 32, data and address width in bits.
REQ-002 Parameter RRSTART, default 1, last-granted index loaded at reset, so requester 0 wins the first tie.
REQ-003 CLK  in  1  single clock; all state changes on rising edge.
REQ-004 RESET  in  1  reset is synchronous and active-high.
REQ-005 R0_REQ  in  1  requester 0 (CPU) access request; held until R0_ACK.
REQ-006 R0_WE  in  1  requester 0 write (1) / read (0); stable while R0_REQ high.
REQ-007 R0_ADDR  in  DBITS  requester 0 byte address; stable while R0_REQ high.
REQ-008 R0_DIN  in  DBITS  requester 0 write data; stable while R0_REQ high.
REQ-009 R0_ACK  out  1  one-cycle completion pulse to requester 0.
REQ-010 R0_DOUT  out  DBITS  registered read data for requester 0; valid while R0_ACK high, held after.
REQ-011 R1_REQ, R1_WE, R1_ADDR, R1_DIN, R1_ACK, R1_DOUT  as REQ-005..010, for requester 1 (DMA/debug).
REQ-012 M_ADDR  out  DBITS  address to data memory/I-O block.
REQ-013 M_DIN  out  DBITS  write data to data memory/I-O block.
REQ-014 M_WE  out  1  write enable to data memory/I-O block.
REQ-015 M_DOUT  in  DBITS  combinational read data from data memory/I-O block.

Function
REQ-016 FSM states IDLE, GNT0, GNT1; exactly one state active.
REQ-017 IDLE: neither REQ high -> IDLE; one REQ high -> that requester's GNT state; both high -> GNT of the requester not last granted.
REQ-018 GNTx: M_ADDR=Rx_ADDR, M_DIN=Rx_DIN, M_WE=Rx_WE for exactly one cycle; next state IDLE.
REQ-019 IDLE: M_ADDR=0, M_DIN=0, M_WE=0.
REQ-020 On the edge leaving GNTx: Rx_DOUT<=M_DOUT if Rx_WE=0, else unchanged; Rx_ACK<=1; last-granted<=x.
REQ-021 Rx_ACK high exactly one cycle, never both ACKs in the same cycle.
REQ-022 Latency: REQ sampled high in IDLE at edge N -> memory access in cycle N..N+1 -> ACK high in cycle after edge N+1; throughput one access per 2 cycles.
REQ-023 A REQ high during its own ACK cycle is a new request; requester drops REQ on ACK if idle.
REQ-024 Starvation bound: a continuously asserted request is granted within 2 arbitration decisions.
REQ-025 A REQ dropped before grant is ignored with no access and no ACK; a REQ dropped during GNTx does not abort the access.
REQ-026 Address-agnostic: I/O addresses (0xFFFF0000..0xFFFF0120) pass through unchanged; no decoding.
REQ-027 M_WE SHALL be 0 whenever RESET is high, regardless of state.

Reset
REQ-028 On RESET at an edge: state<=IDLE, R0_ACK<=0, R1_ACK<=0, R0_DOUT<=0, R1_DOUT<=0, last-granted<=RRSTART.
REQ-029 Reset in GNTx: access aborted, no ACK issued, no write reaches memory.
REQ-030 Requests held through reset are re-arbitrated normally from IDLE after RESET drops.

Structure
REQ-031 Shared package dmem_pkg holds the FSM state enum (IDLE/GNT0/GNT1) and DBITS default.
REQ-032 One sub-module is natural: rr_pick2 (combinational two-way round-robin picker from REQs and last-granted); the remainder stays in dmem_arbiter.

Verification
REQ-033 Reset, R0 read 0x00000010 with M_DOUT=0xDEADBEEF -> M_ADDR=0x10 one cycle, M_WE=0, R0_ACK next cycle, R0_DOUT=0xDEADBEEF.
REQ-034 R1 write 0xFFFF0000 data 0x0000BEEF -> M_WE high exactly one cycle with M_ADDR=0xFFFF0000, M_DIN=0xBEEF; R1_ACK follows; R1_DOUT unchanged.
REQ-035 Both REQ high continuously from reset, 6 accesses -> grant order 0,1,0,1,0,1; no ACK overlap.
REQ-036 R0 held high continuously, R1 pulsed once -> R1 granted at next decision after the in-flight R0 access.
REQ-037 RESET asserted during GNT1 write -> M_WE=0 that cycle, no R1_ACK, memory word unchanged; after release R1 (still requesting) granted next.
REQ-038 R0_REQ high one cycle then low while FSM busy with R1 -> no R0 access, no R0_ACK.
